// File: rtl/layer1_accumulator_if.sv
// Stream bundle between the layer-1 systolic array, the tap accumulator and
// the pixel consumer. The master drives beats and back-pressure; the slave is the accumulator.
interface layer1_accumulator_if;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] psum_in;
  logic [127:0] bias;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         frame_done;
  logic [15:0]  pixel_cnt;

  modport master (
    output clear, in_valid, psum_in, bias, out_ready,
    input  in_ready, out_valid, out_data, frame_done, pixel_cnt
  );

  modport slave (
    input  clear, in_valid, psum_in, bias, out_ready,
    output in_ready, out_valid, out_data, frame_done, pixel_cnt
  );
endinterface

// File: rtl/layer1_accumulator.sv
// Layer-1 tap accumulator: sums TAPS partial dot products per channel, adds
// bias, shifts, applies ReLU + 16-bit saturation and counts output pixels per frame.
module layer1_accumulator #(
  parameter int TAPS   = 9,
  parameter int ACC_W  = 24,
  parameter int SHIFT  = 0,
  parameter int PIXELS = 900
) (
  input  logic                 clk,
  input  logic                 rst_n,
  layer1_accumulator_if.slave  bus
);

  localparam int NCH   = 8;
  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(32767);

  logic [TAP_W-1:0]        tap_cnt_q, tap_cnt_d;
  logic signed [ACC_W-1:0] acc_q [NCH];
  logic signed [ACC_W-1:0] acc_d [NCH];
  logic                    out_valid_q, out_valid_d;
  logic [127:0]            out_data_q, out_data_d;
  logic                    frame_done_q, frame_done_d;
  logic [15:0]             pixel_cnt_q, pixel_cnt_d;

  logic         last_tap;
  logic         accept;
  logic         fire;
  logic         handshake;
  logic [127:0] pixel_new;

  function automatic logic signed [ACC_W-1:0] sext16(input logic [15:0] x);
    return {{(ACC_W-16){x[15]}}, x};
  endfunction

  // One bit of headroom so acc + psum + bias never wraps before saturation.
  function automatic logic signed [ACC_W:0] final_sum(
    input logic signed [ACC_W-1:0] a,
    input logic [15:0]             p,
    input logic [15:0]             b
  );
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W-15){p[15]}}, p} + {{(ACC_W-15){b[15]}}, b};
    return s >>> SHIFT;
  endfunction

  function automatic logic [15:0] relu_sat(input logic signed [ACC_W:0] v);
    logic [15:0] r;
    if (v[ACC_W])
      r = 16'h0000;
    else if (v > SAT_MAX)
      r = 16'h7fff;
    else
      r = v[15:0];
    return r;
  endfunction

  // Only the final tap can stall; in_ready depends combinationally on out_ready.
  assign last_tap  = (tap_cnt_q == TAP_W'(TAPS-1));
  assign accept    = bus.in_valid & bus.in_ready;
  assign fire      = accept & last_tap & ~bus.clear;
  assign handshake = out_valid_q & bus.out_ready;

  assign bus.in_ready   = ~last_tap | ~out_valid_q | bus.out_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pixel_cnt  = pixel_cnt_q;

  always_comb begin
    pixel_new = '0;
    for (int k = 0; k < NCH; k++) begin
      pixel_new[16*k +: 16] = relu_sat(final_sum(acc_q[k], bus.psum_in[16*k +: 16],
                                                 bus.bias[16*k +: 16]));
    end
  end

  always_comb begin
    tap_cnt_d = tap_cnt_q;
    for (int k = 0; k < NCH; k++) acc_d[k] = acc_q[k];
    if (bus.clear || fire) begin
      tap_cnt_d = '0;
      for (int k = 0; k < NCH; k++) acc_d[k] = '0;
    end else if (accept) begin
      tap_cnt_d = tap_cnt_q + TAP_W'(1);
      for (int k = 0; k < NCH; k++) acc_d[k] = acc_q[k] + sext16(bus.psum_in[16*k +: 16]);
    end
  end

  always_comb begin
    out_valid_d  = fire | (out_valid_q & ~bus.out_ready);
    out_data_d   = fire ? pixel_new : out_data_q;
    frame_done_d = 1'b0;
    pixel_cnt_d  = pixel_cnt_q;
    if (handshake) begin
      if (pixel_cnt_q == 16'(PIXELS-1)) begin
        pixel_cnt_d  = '0;
        frame_done_d = 1'b1;
      end else begin
        pixel_cnt_d = pixel_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_cnt_q    <= '0;
      for (int k = 0; k < NCH; k++) acc_q[k] <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      pixel_cnt_q  <= '0;
    end else begin
      tap_cnt_q    <= tap_cnt_d;
      for (int k = 0; k < NCH; k++) acc_q[k] <= acc_d[k];
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
      pixel_cnt_q  <= pixel_cnt_d;
    end
  end

endmodule

// File: tb/tb_layer1_accumulator.sv
// Directed bench for layer1_accumulator with a per-cycle reference model
// (integer sums and a pixel queue) and hand-computed literal expectations.
module tb_layer1_accumulator;

  localparam int TAPS   = 9;
  localparam int ACC_W  = 24;
  localparam int SHIFT  = 0;
  localparam int PIXELS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  layer1_accumulator_if bus();

  layer1_accumulator #(
    .TAPS(TAPS), .ACC_W(ACC_W), .SHIFT(SHIFT), .PIXELS(PIXELS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rep(input logic [15:0] v);
    return {8{v}};
  endfunction

  // Reference model: what the block must do, from the arithmetic rules.
  int            m_sum [8];
  int            m_tap = 0;
  int            m_pix = 0;
  bit            exp_fd = 1'b0;
  logic [127:0]  exp_q [$];
  int            ov_cnt = 0;
  int            cyc = 0;
  int            last_ov_cyc = -1;
  bit            spacing_on = 1'b0;

  always @(negedge clk) begin
    bit           m_ready;
    bit           m_valid;
    int           v;
    logic [127:0] px;
    cyc++;
    if (!rst_n) begin
      chk("reset in_ready", bus.in_ready, 1);
      chk("reset out_valid", bus.out_valid, 0);
      chk("reset out_data", bus.out_data, 0);
      chk("reset frame_done", bus.frame_done, 0);
      chk("reset pixel_cnt", bus.pixel_cnt, 0);
      exp_q.delete();
      m_tap  = 0;
      m_pix  = 0;
      exp_fd = 1'b0;
      for (int k = 0; k < 8; k++) m_sum[k] = 0;
    end else begin
      m_valid = (exp_q.size() != 0);
      m_ready = (m_tap != TAPS-1) || !m_valid || bus.out_ready;
      chk("model in_ready", bus.in_ready, m_ready);
      chk("model out_valid", bus.out_valid, m_valid);
      if (m_valid) chk("model out_data", bus.out_data, exp_q[0]);
      chk("model pixel_cnt", bus.pixel_cnt, 16'(m_pix));
      chk("model frame_done", bus.frame_done, exp_fd);
      if (bus.out_valid) begin
        ov_cnt++;
        if (spacing_on && last_ov_cyc >= 0) chk("output spacing", 32'(cyc - last_ov_cyc), TAPS);
        last_ov_cyc = cyc;
      end
      exp_fd = 1'b0;
      if (m_valid && bus.out_ready) begin
        void'(exp_q.pop_front());
        if (m_pix == PIXELS-1) begin
          m_pix  = 0;
          exp_fd = 1'b1;
        end else begin
          m_pix++;
        end
      end
      if (bus.clear) begin
        m_tap = 0;
        for (int k = 0; k < 8; k++) m_sum[k] = 0;
      end else if (bus.in_valid && m_ready) begin
        if (m_tap == TAPS-1) begin
          px = '0;
          for (int k = 0; k < 8; k++) begin
            v = m_sum[k] + int'($signed(bus.psum_in[16*k +: 16])) + int'($signed(bus.bias[16*k +: 16]));
            v = v >>> SHIFT;
            if (v < 0) v = 0;
            else if (v > 32767) v = 32767;
            px[16*k +: 16] = 16'(v);
            m_sum[k] = 0;
          end
          exp_q.push_back(px);
          m_tap = 0;
        end else begin
          for (int k = 0; k < 8; k++) m_sum[k] += int'($signed(bus.psum_in[16*k +: 16]));
          m_tap++;
        end
      end
    end
  end

  task automatic send_beat(input logic [127:0] p, input logic [127:0] b);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.psum_in  = p;
    bus.bias     = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL beat accept timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Non-final beats carry a different bias so only the final-tap sample may matter.
  task automatic send_pixel(input logic [127:0] p, input logic [127:0] b);
    for (int i = 0; i < TAPS; i++) send_beat(p, (i == TAPS-1) ? b : ~b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.psum_in   = '0;
    bus.bias      = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("lit reset out_valid", bus.out_valid, 0);
    chk("lit reset in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain accumulation: 9 x 100.
    send_pixel(rep(16'd100), rep(16'd0));
    chk("lit t1 out_valid", bus.out_valid, 1);
    chk("lit t1 out_data", bus.out_data, rep(16'd900));
    @(posedge clk); #1;
    chk("lit t1 drained", bus.out_valid, 0);
    chk("lit t1 pixel_cnt", bus.pixel_cnt, 1);

    // ReLU on channel 1, saturation on channel 2.
    send_pixel({{6{16'h0000}}, 16'd4000, 16'hffce}, {{6{16'h0000}}, 16'h0000, 16'd200});
    chk("lit t2 relu/sat", bus.out_data, {{6{16'h0000}}, 16'h7fff, 16'h0000});
    @(posedge clk); #1;

    // Back-pressure: final tap waits for output space.
    bus.out_ready = 1'b0;
    send_pixel(rep(16'd10), rep(16'd0));
    chk("lit t3 pending", bus.out_data, rep(16'd90));
    for (int i = 0; i < TAPS-1; i++) send_beat(rep(16'd20), rep(16'd5));
    bus.in_valid = 1'b1;
    bus.psum_in  = rep(16'd20);
    bus.bias     = rep(16'd1);
    @(negedge clk);
    chk("lit t3 stall in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    chk("lit t3 held data", bus.out_data, rep(16'd90));
    @(negedge clk);
    chk("lit t3 stall in_ready 2", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    #1;
    chk("lit t3 ready path", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("lit t3 no bubble", bus.out_valid, 1);
    chk("lit t3 new pixel", bus.out_data, rep(16'd181));
    chk("lit t3 pixel_cnt", bus.pixel_cnt, 3);
    @(posedge clk); #1;
    chk("lit frame_done pulse", bus.frame_done, 1);
    chk("lit frame wrap", bus.pixel_cnt, 0);
    @(posedge clk); #1;
    chk("lit frame_done drop", bus.frame_done, 0);

    // Back-to-back pixels with constant out_ready.
    ov_cnt      = 0;
    last_ov_cyc = -1;
    spacing_on  = 1'b1;
    for (int px = 1; px <= 3; px++) send_pixel(rep(16'(px)), rep(16'd0));
    repeat (2) @(posedge clk);
    #1;
    spacing_on = 1'b0;
    chk("lit t4 output count", 32'(ov_cnt), 3);

    // Clear drops a partial sum, leaves the pending output alone.
    bus.out_ready = 1'b0;
    send_pixel(rep(16'd7), rep(16'd0));
    for (int i = 0; i < 4; i++) send_beat(rep(16'd1000), rep(16'd0));
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.psum_in  = rep(16'd1000);
    @(posedge clk); #1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    chk("lit t5 pending kept", bus.out_data, rep(16'd63));
    for (int i = 0; i < TAPS-1; i++) send_beat(rep(16'd1), rep(16'd0));
    chk("lit t5 still pending", bus.out_data, rep(16'd63));
    bus.out_ready = 1'b1;
    send_beat(rep(16'd1), rep(16'd0));
    chk("lit t5 cleared sum", bus.out_data, rep(16'd9));
    @(posedge clk); #1;

    // Async reset mid-pixel with an output pending.
    bus.out_ready = 1'b0;
    send_pixel(rep(16'd5), rep(16'd0));
    for (int i = 0; i < 3; i++) send_beat(rep(16'd50), rep(16'd0));
    rst_n = 1'b0;
    #1;
    chk("lit t6 reset out_valid", bus.out_valid, 0);
    chk("lit t6 reset pixel_cnt", bus.pixel_cnt, 0);
    chk("lit t6 reset out_data", bus.out_data, 0);
    @(posedge clk); #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    send_pixel(rep(16'd3), rep(16'd0));
    chk("lit t6 clean result", bus.out_data, rep(16'd27));
    @(posedge clk); #1;
    chk("lit t6 pixel_cnt", bus.pixel_cnt, 1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
